// File: rtl/svm_pkg.sv
// svm_pkg: shared job-controller state encoding and default sizing constants.
package svm_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, REQ, CLASS_END, DONE} job_state_t;
    localparam int NUM_CLASSES_DEF = 10;
    localparam int CNT_W_DEF       = 10;
    localparam int ADDR_W_DEF      = 14;
endpackage

// File: rtl/svm_job_ctrl.sv
// svm_job_ctrl: walks every class of a job, issuing one SV memory read per support vector,
// with per-class and per-job completion signalling back to the control side.
module svm_job_ctrl
    import svm_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int CLASS_W     = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               ready,
    output logic               done_intr_o,
    output logic [CLASS_W-1:0] class_o,
    input  logic [CNT_W-1:0]   sv_cnt_i,
    output logic               rd_req_o,
    output logic [ADDR_W-1:0]  rd_addr_o,
    input  logic               rd_ack_i,
    output logic               class_done_o
);
    job_state_t         state_q, state_d;
    logic [CLASS_W-1:0] class_q, class_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, limit_q, limit_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               ready_q, ready_d, done_q, done_d;
    logic               last_class;

    assign last_class = class_q == CLASS_W'(NUM_CLASSES - 1);

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        cnt_d   = cnt_q;
        limit_d = limit_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                class_d = '0;
                addr_d  = '0;
                cnt_d   = '0;
                if (start) state_d = LOAD;
            end
            LOAD: begin
                limit_d = sv_cnt_i;
                cnt_d   = '0;
                state_d = (sv_cnt_i == '0) ? CLASS_END : REQ;
            end
            REQ: begin
                if (rd_ack_i) begin
                    addr_d = addr_q + 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_d == limit_q) state_d = CLASS_END;
                end
            end
            CLASS_END: begin
                if (last_class) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    class_d = class_q + 1'b1;
                    state_d = LOAD;
                end
            end
            DONE: begin
                // Leaving only on a low start keeps a held command from retriggering.
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = state_d == IDLE;
    end

    // ready is registered so it reads 0 while reset is held, 1 once released.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            class_q <= '0;
            cnt_q   <= '0;
            limit_q <= '0;
            addr_q  <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
            addr_q  <= addr_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign ready        = ready_q;
    assign done_intr_o  = done_q;
    assign class_o      = class_q;
    assign rd_req_o     = state_q == REQ;
    assign rd_addr_o    = addr_q;
    assign class_done_o = state_q == CLASS_END;
endmodule

// File: tb/tb_svm_job_ctrl.sv
// tb_svm_job_ctrl: scoreboard bench; stimulus queues expected reads/class-ends/job-ends,
// a negedge monitor pops and compares them as the controller presents each event.
module tb_svm_job_ctrl;
    localparam int EV_READ = 0, EV_CLASS = 1, EV_DONE = 2;
    typedef struct {int kind; int val;} ev_t;

    logic       clk, reset, start, ready, done_intr_o, class_o;
    logic [9:0] sv_cnt_i;
    logic       rd_req_o, rd_ack_i, class_done_o;
    logic [2:0] rd_addr_o;
    logic [9:0] sv_tab [2];

    ev_t exp_q[$];
    int  checks = 0, errors = 0;
    int  ack_mode = 0, cyc = 0, n;
    logic       prev_stall = 1'b0;
    logic [2:0] prev_addr = '0;

    svm_job_ctrl #(.NUM_CLASSES(2), .CNT_W(10), .ADDR_W(3)) dut (
        .clk(clk), .reset(reset), .start(start), .ready(ready), .done_intr_o(done_intr_o),
        .class_o(class_o), .sv_cnt_i(sv_cnt_i), .rd_req_o(rd_req_o), .rd_addr_o(rd_addr_o),
        .rd_ack_i(rd_ack_i), .class_done_o(class_done_o)
    );

    assign sv_cnt_i = sv_tab[class_o];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic pop_ev(input int kind, input int val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d val %0d expected none at %0t", kind, val, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                errors++;
                $display("FAIL event: got kind %0d val %0d expected kind %0d val %0d at %0t",
                         kind, val, e.kind, e.val, $time);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (prev_stall) chk("stall_hold", {28'd0, rd_req_o, rd_addr_o}, {28'd0, 1'b1, prev_addr});
                if (rd_req_o && rd_ack_i) pop_ev(EV_READ, int'(rd_addr_o));
                if (class_done_o) pop_ev(EV_CLASS, int'(class_o));
                if (done_intr_o) pop_ev(EV_DONE, 0);
                prev_stall = rd_req_o && !rd_ack_i;
                prev_addr  = rd_addr_o;
            end else prev_stall = 1'b0;
        end
    end

    initial begin
        rd_ack_i = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            #1 rd_ack_i = (ack_mode != 0) ? (cyc % 3 == 0) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int c0, input int c1);
        int a = 0;
        int k[2];
        k[0] = c0;
        k[1] = c1;
        sv_tab[0] = 10'(c0);
        sv_tab[1] = 10'(c1);
        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < k[c]; i++) begin
                exp_q.push_back('{EV_READ, a % 8});
                a++;
            end
            exp_q.push_back('{EV_CLASS, c});
        end
        exp_q.push_back('{EV_DONE, 0});
        start = 1'b1;
        tick();
        chk("ready_after_accept", int'(ready), 0);
    endtask

    task automatic finish_job(input int hold, output int cycles);
        cycles = 0;
        while (!done_intr_o && cycles < 300) begin
            tick();
            cycles++;
        end
        chk("done_seen", int'(done_intr_o), 1);
        repeat (hold) tick();
        if (hold > 0) begin
            chk("held_ready", int'(ready), 0);
            chk("held_done_low", int'(done_intr_o), 0);
        end
        start = 1'b0;
        tick();
        chk("ready_return", int'(ready), 1);
        tick();
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        sv_tab[0] = '0;
        sv_tab[1] = '0;
        repeat (3) tick();
        chk("rst_ready", int'(ready), 0);
        chk("rst_req", int'(rd_req_o), 0);
        chk("rst_cdone", int'(class_done_o), 0);
        chk("rst_done", int'(done_intr_o), 0);
        chk("rst_addr", int'(rd_addr_o), 0);
        chk("rst_class", int'(class_o), 0);
        reset = 1'b1;
        tick();
        chk("ready_after_release", int'(ready), 1);

        start_job(3, 2);
        finish_job(0, n);
        chk("basic_job_len", n, 9);

        ack_mode = 1;
        start_job(4, 0);
        finish_job(0, n);
        ack_mode = 0;

        start_job(0, 2);
        chk("zero_cdone_early", int'(class_done_o), 0);
        tick();
        chk("zero_cdone", int'(class_done_o), 1);
        chk("zero_cdone_class", int'(class_o), 0);
        finish_job(0, n);

        start_job(1, 1);
        finish_job(20, n);

        start_job(3, 2);
        n = 0;
        while (!(rd_req_o && rd_addr_o == 3'd4) && n < 100) begin
            tick();
            n++;
        end
        chk("reached_class1_read2", int'(rd_req_o && rd_addr_o == 3'd4), 1);
        reset = 1'b0;
        start = 1'b0;
        tick();
        chk("midrst_ready", int'(ready), 0);
        chk("midrst_req", int'(rd_req_o), 0);
        chk("midrst_addr", int'(rd_addr_o), 0);
        chk("midrst_class", int'(class_o), 0);
        chk("midrst_cdone", int'(class_done_o), 0);
        exp_q.delete();
        reset = 1'b1;
        tick();
        chk("midrst_ready_release", int'(ready), 1);
        start_job(3, 2);
        finish_job(0, n);

        start_job(6, 4);
        finish_job(0, n);
        chk("wrap_job_len", n, 14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
